// File: rtl/rr_arbiter_8_pkg.sv
// rtl/rr_arbiter_8_pkg.sv - shared constants and FSM encoding for the 8-way round-robin arbiter
package rr_arbiter_8_pkg;

   localparam int N_REQ            = 8;
   localparam int IDX_W            = 3;
   localparam int CNT_W            = 8;
   localparam int DEFAULT_MAX_HOLD = 16;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

endpackage

// File: rtl/decoder_3_8.sv
// rtl/decoder_3_8.sv - 3-to-8 one-hot decoder with enable
module decoder_3_8 (
   input  logic [2:0] in,
   input  logic       en,
   output logic [7:0] out
);

   always_comb begin
      out = 8'h00;
      if (en) begin
         out = 8'h01 << in;
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter for a shared write port
// Grants are held until done, request drop, or MAX_HOLD expiry; one IDLE cycle separates grants.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand;
   logic             expire;
   logic             owner_req;
   logic             release_now;

   // Round-robin scan: first set request starting at ptr, wrapping mod 8.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr + IDX_W'(k);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign expire      = (hold_cnt == HOLD_LAST);
   assign owner_req   = req[grant_idx];
   assign release_now = done || !owner_req || expire;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state       <= HOLD;
                  grant_idx   <= pick_idx;
                  grant_valid <= 1'b1;
                  hold_cnt    <= '0;
               end
            end
            HOLD: begin
               if (release_now) begin
                  state       <= IDLE;
                  ptr         <= grant_idx + IDX_W'(1);
                  grant_idx   <= '0;
                  grant_valid <= 1'b0;
                  hold_cnt    <= '0;
                  // Only a pure expiry counts as a timeout; done or req drop wins.
                  timeout     <= expire && !done && owner_req;
               end else if (hold_cnt != CNT_SAT) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   decoder_3_8 u_grant_dec (
      .in  (grant_idx),
      .en  (grant_valid),
      .out (grant)
   );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                             input logic v, input logic t);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
      chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
      chk({tag, ".timeout"}, 32'(timeout), 32'(t));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 8'h00;
      done  = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 8'hFF;
      done  = 1'b1;
      step();
      step();
      expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

      // single requester 2, one-cycle latency
      reset = 1'b0;
      req   = 8'h04;
      done  = 1'b0;
      step();
      expect_out("single_req2", 8'h04, 3'd2, 1'b1, 1'b0);
      req = 8'h00;
      step();
      expect_out("req_drop_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      expect_out("idle_no_req", 8'h00, 3'd0, 1'b0, 1'b0);

      // full rotation with done every HOLD cycle (done in IDLE ignored)
      do_reset();
      req = 8'hFF;
      step();
      expect_out("rot0", 8'h01, 3'd0, 1'b1, 1'b0);
      done = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         logic [2:0] e;
         e = 3'(i % 8);
         step();
         chk($sformatf("rot_gap%0d.valid", i), 32'(grant_valid), 32'd0);
         step();
         chk($sformatf("rot%0d.idx", i), 32'(grant_idx), 32'(e));
         chk($sformatf("rot%0d.grant", i), 32'(grant), 32'(8'h01 << e));
      end
      done = 1'b0;
      req  = 8'h00;
      step();

      // MAX_HOLD=4 expiry with a single persistent requester
      do_reset();
      req = 8'h01;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out($sformatf("hold%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
      end
      step();
      expect_out("expire_release", 8'h00, 3'd0, 1'b0, 1'b1);
      step();
      expect_out("regrant0", 8'h01, 3'd0, 1'b1, 1'b0);

      // done coinciding with expiry: release without timeout
      step();
      step();
      step();
      expect_out("pre_expire", 8'h01, 3'd0, 1'b1, 1'b0);
      done = 1'b1;
      step();
      expect_out("done_and_expire", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      req  = 8'h00;
      step();
      chk("no_late_timeout", 32'(timeout), 32'd0);

      // grant to 3, other requests ignored, then req[3] drop hands over to 5
      do_reset();
      req = 8'h08;
      step();
      expect_out("grant3", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'h0B;
      step();
      expect_out("hold3_stable", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'h20;
      step();
      expect_out("drop3", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      expect_out("grant5", 8'h20, 3'd5, 1'b1, 1'b0);

      // reset mid-HOLD at index 6, pointer restarts at 0
      do_reset();
      req = 8'h40;
      step();
      expect_out("grant6", 8'h40, 3'd6, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      expect_out("reset_mid_hold", 8'h00, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      req   = 8'h41;
      step();
      expect_out("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum cycles one grant may be held before forced release (legal 2..255).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared write port.
REQ-005 done  input  1  granted requester signals end of its transfer.
REQ-006 grant  output  8  one-hot grant, at most one bit set.
REQ-007 grant_idx  output  3  binary index of granted requester; valid only when grant_valid=1.
REQ-008 grant_valid  output  1  high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and HOLD.
REQ-011 In IDLE, with req != 0 at edge N, the block SHALL enter HOLD and present grant/grant_idx/grant_valid from edge N onward (visible cycle N+1; one-cycle latency).
REQ-012 Selection SHALL be round-robin: first set req bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
REQ-013 ptr SHALL reset to 0 and, on every release, load (grant_idx+1) mod 8.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs 0.
REQ-015 In HOLD, grant, grant_idx and ptr SHALL remain constant regardless of other req bits.
REQ-016 HOLD SHALL release to IDLE on the first edge where any of: done=1; req[grant_idx]=0; hold counter reaches MAX_HOLD-1.
REQ-017 The hold counter SHALL clear on entry to HOLD, increment each HOLD cycle, and saturate, never wrapping.
REQ-018 When release is due only to the counter, timeout SHALL pulse high for exactly the cycle after release; done or req drop in the same cycle takes precedence, with no timeout.
REQ-019 After release, at least one IDLE cycle SHALL separate consecutive grants; earliest regrant is visible two cycles after the releasing edge.
REQ-020 grant SHALL always equal the one-hot decode of grant_idx gated by grant_valid.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 With a single persistent requester, that requester SHALL be regranted after every release.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, ptr=0, counter=0, grant=0, grant_idx=0, grant_valid=0, timeout=0, overriding all other inputs including mid-HOLD.
REQ-024 The first edge after reset deasserts SHALL evaluate req normally; no extra wait cycle.

Structure
REQ-025 FSM state encodings, requester count (8) and default MAX_HOLD SHALL live in the shared project package/include; no local redefinition.
REQ-026 One-hot grant generation SHALL instantiate the existing decoder_3_8 with in=grant_idx and en=grant_valid; the round-robin priority scan stays inline.
REQ-027 All outputs SHALL be driven from registers or the decoder on registered inputs; no combinational path from req/done to outputs.

Verification
REQ-028 Reset, then req=8'b0000_0100 at cycle 1 -> cycle 2: grant=8'h04, grant_idx=2, grant_valid=1.
REQ-029 req=8'hFF held, done pulsed each HOLD cycle -> grant_idx sequence 0,1,2,...,7,0 with one IDLE cycle between grants.
REQ-030 MAX_HOLD=4, req=8'h01 held, done=0 -> grant held exactly 4 cycles, timeout pulses once, regrant to 0 two cycles after release.
REQ-031 Grant to 3, then req[3] dropped while req[5]=1 -> release next edge; next grant_idx=5 with no timeout.
REQ-032 reset asserted mid-HOLD (grant_idx=6) -> next cycle all outputs 0; with req=8'h41 after reset, grant_idx=0 (ptr restarted at 0).
REQ-033 done and counter expiry on the same edge -> release, timeout stays 0.
